// File: rtl/chiplet_types_pkg.sv
// Shared types and register map for the chiplet endpoint receive path.
//   vc_t       : virtual channel index (up to 8 VCs)
//   metadata_t : per-flit sideband (tag + VC)
//   flit_t     : metadata + 32-bit payload
//   ctrl_t     : CTRL register fields
// Also holds bus addresses, the idle read pattern and the drop counter ceiling.
package chiplet_types_pkg;

    typedef logic [2:0] vc_t;

    typedef struct packed {
        logic [7:0] tag;
        vc_t        vc;
    } metadata_t;

    typedef struct packed {
        metadata_t   metadata;
        logic [31:0] payload;
    } flit_t;

    typedef struct packed {
        vc_t  sel_vc;
        logic irq_en;
        logic mode;
    } ctrl_t;

    localparam logic [31:0] ADDR_RX_READY    = 32'h0000_1000;
    localparam logic [31:0] ADDR_RX_PAYLOAD  = 32'h0000_1004;
    localparam logic [31:0] ADDR_RX_METADATA = 32'h0000_1008;
    localparam logic [31:0] ADDR_CTRL        = 32'h0000_100C;
    localparam logic [31:0] ADDR_STATUS      = 32'h0000_1010;
    localparam logic [31:0] ADDR_COUNT       = 32'h0000_1014;

    localparam logic [31:0] RDATA_IDLE = 32'hBAD1_BAD1;
    localparam logic [15:0] DROP_MAX   = 16'hFFFF;

    function automatic logic [31:0] ctrl_to_word(ctrl_t c);
        return {21'b0, c.sel_vc, 6'b0, c.irq_en, c.mode};
    endfunction

endpackage

// File: rtl/bus_protocol_if.sv
// Simple single-cycle register bus.
//   peripheral_vital : addr, wen, ren, wdata in; rdata, error, request_stall out
//   host             : mirror image for the bus master
interface bus_protocol_if;
    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    modport peripheral_vital (
        input  addr, wen, ren, wdata,
        output rdata, error, request_stall
    );

    modport host (
        output addr, wen, ren, wdata,
        input  rdata, error, request_stall
    );
endinterface

// File: rtl/vc_rx_fifo.sv
// Per-VC receive queue: synchronous FIFO with a combinational head.
//   clk, rst       : clock, synchronous active-high reset (empties the queue)
//   push_i/wdata_i : enqueue; accepted when not full, or when full and popping
//   pop_i          : dequeue the head; ignored when empty
//   rdata_o        : current head entry
//   full_o/empty_o : occupancy flags from registered state
//   count_o        : occupancy 0..DEPTH
module vc_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full queue may still accept when its head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/endpoint_rx_vc.sv
// Endpoint receive block: per-VC flit queues drained by register reads.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : switch presents in_flit (VC from in_flit.metadata.vc)
//   in_ready      : per-VC not-full, from registered occupancy
//   credit_return : one-cycle pulse per flit dequeued from that VC
//   irq           : registered irq_en & (any VC non-empty)
//   bus_if        : single-cycle register port (never stalls)
module endpoint_rx_vc
    import chiplet_types_pkg::*;
#(
    parameter int NUM_VCS = 2,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  flit_t                    in_flit,
    output logic [NUM_VCS-1:0]       in_ready,
    output logic [NUM_VCS-1:0]       credit_return,
    output logic                     irq,
    bus_protocol_if.peripheral_vital bus_if
);
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int FLIT_W = $bits(flit_t);
    localparam int META_W = $bits(metadata_t);

    logic [NUM_VCS-1:0] push, pop, full, empty, nonempty;
    logic [CW-1:0]      count [NUM_VCS];
    logic [FLIT_W-1:0]  head  [NUM_VCS];

    ctrl_t              ctrl_q, ctrl_d;
    vc_t                rr_ptr_q, rr_ptr_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_q, drop_d;
    logic [NUM_VCS-1:0] credit_q;
    logic               irq_q;

    vc_t                cur_vc, in_vc;
    flit_t              cur_head;
    logic [CW-1:0]      cur_count;
    logic               cur_nonempty;
    logic               pay_pop, ctrl_we, status_clr, drop, rr_found;

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        vc_rx_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[v]),
            .wdata_i (in_flit),
            .pop_i   (pop[v]),
            .rdata_o (head[v]),
            .full_o  (full[v]),
            .empty_o (empty[v]),
            .count_o (count[v])
        );
    end

    assign nonempty      = ~empty;
    assign in_ready      = ~full;
    assign credit_return = credit_q;
    assign irq           = irq_q;
    assign in_vc         = in_flit.metadata.vc;
    assign cur_vc        = ctrl_q.mode ? rr_ptr_q : ctrl_q.sel_vc;

    always_comb begin
        cur_head     = '0;
        cur_count    = '0;
        cur_nonempty = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (cur_vc == vc_t'(v)) begin
                cur_head     = flit_t'(head[v]);
                cur_count    = count[v];
                cur_nonempty = nonempty[v];
            end
        end
    end

    // Register decode; all accesses complete in the cycle they are presented.
    always_comb begin
        bus_if.rdata         = RDATA_IDLE;
        bus_if.error         = 1'b0;
        bus_if.request_stall = 1'b0;
        pay_pop              = 1'b0;
        ctrl_we              = 1'b0;
        status_clr           = 1'b0;
        case (bus_if.addr)
            ADDR_RX_READY: begin
                if (bus_if.ren) bus_if.rdata = 32'(nonempty);
            end
            ADDR_RX_PAYLOAD: begin
                if (bus_if.ren) begin
                    if (cur_nonempty) begin
                        bus_if.rdata = cur_head.payload;
                        pay_pop      = 1'b1;
                    end else begin
                        bus_if.error = 1'b1;
                    end
                end
            end
            ADDR_RX_METADATA: begin
                if (bus_if.ren)
                    bus_if.rdata = cur_nonempty ? {{(32-META_W){1'b0}}, cur_head.metadata} : '0;
            end
            ADDR_CTRL: begin
                if (bus_if.ren) bus_if.rdata = ctrl_to_word(ctrl_q);
                if (bus_if.wen) begin
                    if (32'(bus_if.wdata[10:8]) >= 32'(NUM_VCS)) bus_if.error = 1'b1;
                    else                                         ctrl_we      = 1'b1;
                end
            end
            ADDR_STATUS: begin
                if (bus_if.ren) bus_if.rdata = {drop_q, 5'b0, cur_vc, 7'b0, overflow_q};
                if (bus_if.wen) status_clr = 1'b1;
            end
            ADDR_COUNT: begin
                if (bus_if.ren) bus_if.rdata = 32'(cur_count);
            end
            default: begin
                if (bus_if.ren || bus_if.wen) bus_if.error = 1'b1;
            end
        endcase
    end

    // Pushing into a full VC is legal only when that VC pops in the same cycle.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            pop[v]  = pay_pop && (cur_vc == vc_t'(v));
            push[v] = in_valid && (in_vc == vc_t'(v)) && (!full[v] || pop[v]);
        end
    end

    // An out-of-range VC never matches any queue, so it falls into the drop path.
    assign drop = in_valid && (push == '0);

    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (status_clr) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_d != DROP_MAX) drop_d = drop_d + 16'd1;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_we) begin
            ctrl_d.sel_vc = bus_if.wdata[10:8];
            ctrl_d.irq_en = bus_if.wdata[1];
            ctrl_d.mode   = bus_if.wdata[0];
        end
    end

    // Round-robin: cyclic search starting after rr_ptr, rr_ptr itself last.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        rr_found = 1'b0;
        if (ctrl_q.mode && (pay_pop || !cur_nonempty)) begin
            for (int i = 1; i <= NUM_VCS; i++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    if (!rr_found && nonempty[v] && (v == (int'(rr_ptr_q) + i) % NUM_VCS)) begin
                        rr_ptr_d = vc_t'(v);
                        rr_found = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            credit_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            credit_q   <= pop;
            irq_q      <= ctrl_q.irq_en && (nonempty != '0);
        end
    end

endmodule

// File: tb/tb_endpoint_rx_vc.sv
module tb_endpoint_rx_vc;
    import chiplet_types_pkg::*;

    localparam int NV  = 2;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    flit_t         in_flit;
    logic [NV-1:0] in_ready;
    logic [NV-1:0] credit_return;
    logic          irq;

    bus_protocol_if bus ();

    always #5 clk = ~clk;

    endpoint_rx_vc #(.NUM_VCS(NV), .DEPTH(DEP)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_flit       (in_flit),
        .in_ready      (in_ready),
        .credit_return (credit_return),
        .irq           (irq),
        .bus_if        (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queues of flits plus register state.
    flit_t         mq [NV][$];
    bit            m_mode, m_irq_en, m_ovf, m_irq;
    int            m_sel, m_rr, m_drops;
    logic [NV-1:0] m_credit;

    int            cur, invc;
    logic [31:0]   e_rdata;
    bit            e_err, e_pop, e_ctrl_we, e_clr, e_mapped;
    logic [NV-1:0] e_ready, ne_pre;
    bit            found;
    int            sz_in;

    initial begin
        m_mode = 0; m_irq_en = 0; m_ovf = 0; m_irq = 0;
        m_sel = 0; m_rr = 0; m_drops = 0; m_credit = '0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cur       = m_mode ? m_rr : m_sel;
            e_rdata   = 32'hBAD1BAD1;
            e_err     = 0;
            e_pop     = 0;
            e_ctrl_we = 0;
            e_clr     = 0;
            for (int v = 0; v < NV; v++) begin
                e_ready[v] = (mq[v].size() < DEP);
                ne_pre[v]  = (mq[v].size() != 0);
            end
            e_mapped = (bus.addr == 32'h1000) || (bus.addr == 32'h1004) || (bus.addr == 32'h1008) ||
                       (bus.addr == 32'h100C) || (bus.addr == 32'h1010) || (bus.addr == 32'h1014);
            if (!e_mapped) begin
                if (bus.ren || bus.wen) e_err = 1;
            end else if (bus.ren && bus.addr == 32'h1000) begin
                e_rdata = 32'(ne_pre);
            end else if (bus.ren && bus.addr == 32'h1004) begin
                if (mq[cur].size() > 0) begin
                    e_rdata = mq[cur][0].payload;
                    e_pop   = 1;
                end else e_err = 1;
            end else if (bus.ren && bus.addr == 32'h1008) begin
                e_rdata = (mq[cur].size() > 0) ? {21'b0, mq[cur][0].metadata} : 32'h0;
            end else if (bus.ren && bus.addr == 32'h100C) begin
                e_rdata = {21'b0, 3'(m_sel), 6'b0, m_irq_en, m_mode};
            end else if (bus.ren && bus.addr == 32'h1010) begin
                e_rdata = {16'(m_drops), 5'b0, 3'(cur), 7'b0, m_ovf};
            end else if (bus.ren && bus.addr == 32'h1014) begin
                e_rdata = 32'(mq[cur].size());
            end
            if (bus.wen && bus.addr == 32'h100C) begin
                if (int'(bus.wdata[10:8]) >= NV) e_err = 1;
                else e_ctrl_we = 1;
            end
            if (bus.wen && bus.addr == 32'h1010) e_clr = 1;

            chk("cmp_rdata", bus.rdata, e_rdata);
            chk("cmp_error", 32'(bus.error), 32'(e_err));
            chk("cmp_stall", 32'(bus.request_stall), 32'h0);
            chk("cmp_in_ready", 32'(in_ready), 32'(e_ready));
            chk("cmp_credit", 32'(credit_return), 32'(m_credit));
            chk("cmp_irq", 32'(irq), 32'(m_irq));

            if (rst) begin
                for (int v = 0; v < NV; v++) mq[v].delete();
                m_mode = 0; m_irq_en = 0; m_sel = 0; m_rr = 0;
                m_ovf = 0; m_drops = 0; m_credit = '0; m_irq = 0;
            end else begin
                invc  = int'(in_flit.metadata.vc);
                sz_in = (invc < NV) ? mq[invc].size() : 0;
                if (e_pop) void'(mq[cur].pop_front());
                if (e_clr) begin
                    m_ovf   = 0;
                    m_drops = 0;
                end
                if (in_valid) begin
                    if (invc < NV && (sz_in < DEP || (e_pop && cur == invc)))
                        mq[invc].push_back(in_flit);
                    else begin
                        m_ovf = 1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
                m_credit = e_pop ? (NV'(1) << cur) : '0;
                m_irq    = m_irq_en && (ne_pre != 0);
                if (m_mode && (e_pop || !ne_pre[m_rr])) begin
                    found = 0;
                    for (int i = 1; i <= NV; i++) begin
                        if (!found && ne_pre[(m_rr + i) % NV]) begin
                            m_rr  = (m_rr + i) % NV;
                            found = 1;
                        end
                    end
                end
                if (e_ctrl_we) begin
                    m_sel    = int'(bus.wdata[10:8]);
                    m_irq_en = bus.wdata[1];
                    m_mode   = bus.wdata[0];
                end
            end
        end
    end

    // Inputs change 1ns after the rising edge; literal checks at +4ns.
    task automatic drive(bit r, bit v, int vc, logic [7:0] tag, logic [31:0] pay,
                         bit ren, bit wen, logic [31:0] addr, logic [31:0] wdata);
        @(posedge clk);
        #1;
        rst                      = r;
        in_valid                 = v;
        in_flit.metadata.vc      = 3'(vc);
        in_flit.metadata.tag     = tag;
        in_flit.payload          = pay;
        bus.ren                  = ren;
        bus.wen                  = wen;
        bus.addr                 = addr;
        bus.wdata                = wdata;
        #3;
    endtask

    task automatic idle();
        drive(0, 0, 0, 8'h00, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask
    task automatic push(int vc, logic [31:0] pay);
        drive(0, 1, vc, 8'h00, pay, 0, 0, 32'h0, 32'h0);
    endtask
    task automatic push_tag(int vc, logic [7:0] tag, logic [31:0] pay);
        drive(0, 1, vc, tag, pay, 0, 0, 32'h0, 32'h0);
    endtask
    task automatic rd(logic [31:0] addr);
        drive(0, 0, 0, 8'h00, 32'h0, 1, 0, addr, 32'h0);
    endtask
    task automatic wr(logic [31:0] addr, logic [31:0] data);
        drive(0, 0, 0, 8'h00, 32'h0, 0, 1, addr, data);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_flit = '0;
        bus.ren = 0; bus.wen = 0; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 0;
        chk_en = 1;

        // reset state
        rd(32'h100C);
        chk("rst_ctrl", bus.rdata, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h3);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(32'h1010);
        chk("rst_status", bus.rdata, 32'h0);

        // fixed mode pop from VC1
        push_tag(1, 8'h5A, 32'hA5A50001);
        wr(32'h100C, 32'h100);
        rd(32'h1000);
        chk("s1_rx_ready", bus.rdata, 32'h2);
        rd(32'h1008);
        chk("s1_metadata", bus.rdata, 32'h2D1);
        rd(32'h1014);
        chk("s1_count", bus.rdata, 32'h1);
        rd(32'h1004);
        chk("s1_payload", bus.rdata, 32'hA5A50001);
        chk("s1_pay_err", 32'(bus.error), 32'h0);
        idle();
        chk("s1_credit", 32'(credit_return), 32'h2);
        idle();
        chk("s1_credit_off", 32'(credit_return), 32'h0);

        // overflow on VC0, then out-of-range VC
        wr(32'h100C, 32'h0);
        for (int i = 0; i < 4; i++) push(0, 32'h100 + i);
        push(0, 32'h104);
        chk("s2_in_ready_full", 32'(in_ready), 32'h2);
        rd(32'h1010);
        chk("s2_status_ovf", bus.rdata, 32'h0001_0001);
        wr(32'h1010, 32'h0);
        rd(32'h1010);
        chk("s2_status_clr", bus.rdata, 32'h0);
        push(5, 32'hDEAD);
        rd(32'h1010);
        chk("s2_status_badvc", bus.rdata, 32'h0001_0001);
        wr(32'h1010, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(32'h1004);
            chk("s2_drain", bus.rdata, 32'h100 + i);
        end
        rd(32'h1000);
        chk("s2_empty", bus.rdata, 32'h0);

        // round robin
        push(0, 32'h10);
        push(0, 32'h11);
        push(1, 32'h20);
        wr(32'h100C, 32'h1);
        rd(32'h1004);
        chk("s3_rr0", bus.rdata, 32'h10);
        rd(32'h1004);
        chk("s3_rr1", bus.rdata, 32'h20);
        rd(32'h1004);
        chk("s3_rr2", bus.rdata, 32'h11);
        wr(32'h100C, 32'h0);

        // full VC0 with simultaneous push and pop
        for (int i = 0; i < 4; i++) push(0, 32'h30 + i);
        drive(0, 1, 0, 8'h00, 32'h34, 1, 0, 32'h1004, 32'h0);
        chk("s4_pay", bus.rdata, 32'h30);
        chk("s4_in_ready", 32'(in_ready), 32'h2);
        rd(32'h1014);
        chk("s4_count", bus.rdata, 32'h4);
        chk("s4_credit", 32'(credit_return), 32'h1);
        rd(32'h1010);
        chk("s4_status", bus.rdata, 32'h0);
        chk("s4_credit_off", 32'(credit_return), 32'h0);
        for (int i = 1; i < 5; i++) begin
            rd(32'h1004);
            chk("s4_drain", bus.rdata, 32'h30 + i);
        end

        // error paths
        rd(32'h1004);
        chk("s5_empty_err", 32'(bus.error), 32'h1);
        chk("s5_empty_rdata", bus.rdata, 32'hBAD1BAD1);
        wr(32'h100C, 32'h500);
        chk("s5_ctrl_err", 32'(bus.error), 32'h1);
        rd(32'h100C);
        chk("s5_ctrl_kept", bus.rdata, 32'h0);
        rd(32'h2000);
        chk("s5_unmapped_err", 32'(bus.error), 32'h1);
        chk("s5_unmapped_rdata", bus.rdata, 32'hBAD1BAD1);
        idle();
        chk("s5_idle_rdata", bus.rdata, 32'hBAD1BAD1);
        chk("s5_idle_err", 32'(bus.error), 32'h0);

        // irq timing
        wr(32'h100C, 32'h2);
        push(0, 32'h77);
        idle();
        chk("s6_irq_lag", 32'(irq), 32'h0);
        idle();
        chk("s6_irq_up", 32'(irq), 32'h1);
        rd(32'h1004);
        chk("s6_irq_pay", bus.rdata, 32'h77);
        chk("s6_irq_hold", 32'(irq), 32'h1);
        idle();
        chk("s6_irq_hold2", 32'(irq), 32'h1);
        idle();
        chk("s6_irq_down", 32'(irq), 32'h0);

        // reset with flits queued and a pop in flight
        wr(32'h100C, 32'h0);
        push(0, 32'h88);
        push(1, 32'h99);
        drive(1, 0, 0, 8'h00, 32'h0, 1, 0, 32'h1004, 32'h0);
        rd(32'h1000);
        chk("s7_rx_ready", bus.rdata, 32'h0);
        chk("s7_credit", 32'(credit_return), 32'h0);
        chk("s7_in_ready", 32'(in_ready), 32'h3);
        idle();
        chk("s7_credit2", 32'(credit_return), 32'h0);

        idle();
        idle();
        @(posedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
